// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, instruction size and the RV32 base opcodes
// decoded by the controller.
package core_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = (r_count == 2'd0) ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry decode buffer.
// Define FETCH_MISALIGN_CHK_EN to flag misaligned redirects and stall fetch until corrected.
module instr_fetch
    import core_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = AW'(32'h0000_0000)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [DW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc,
    output logic [6:0]    opcode,
    output logic [2:0]    func3,
    output logic [6:0]    func7,
    output logic          misalign
);

    localparam int unsigned EW = DW + AW;

    fetch_state_e  r_state, w_state_d;
    logic [AW-1:0] r_pc, w_pc_d;
    logic [AW-1:0] r_req_addr, w_req_addr_d;
    logic [AW-1:0] w_redir_pc;
    logic [1:0]    w_count;
    logic [EW-1:0] w_head;
    logic          w_push;
    logic          w_req_fire;
    logic          w_outstanding;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_misalign <= 1'b0;
        else if (redirect_valid) r_misalign <= (redirect_pc[1:0] != 2'b00);
    end

    assign misalign   = r_misalign;
    assign w_redir_pc = redirect_pc;
`else
    assign misalign   = 1'b0;
    assign w_redir_pc = redirect_pc & ~AW'(3);
`endif

    assign w_outstanding = (r_state == StWait) || (r_state == StDrop);
    assign mem_req_valid = (r_state == StReq) && ((w_count + {1'b0, w_outstanding}) < 2'd2)
                           && !misalign;
    assign mem_req_addr  = r_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_req_addr_d = r_req_addr;
        w_push       = 1'b0;
        unique case (r_state)
            StIdle: w_state_d = StReq;
            StReq: begin
                if (w_req_fire) begin
                    w_pc_d       = r_pc + AW'(INSTR_BYTES);
                    w_req_addr_d = r_pc;
                    w_state_d    = StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    w_push    = 1'b1;
                    w_state_d = StReq;
                end
            end
            StDrop: if (mem_rsp_valid) w_state_d = StReq;
            default: w_state_d = StIdle;
        endcase
        // A response landing with the redirect settles the outstanding request, so no DROP.
        if (redirect_valid) begin
            w_pc_d = w_redir_pc;
            w_push = 1'b0;
            if (w_req_fire)         w_state_d = StDrop;
            else if (w_outstanding) w_state_d = mem_rsp_valid ? StReq : StDrop;
            else                    w_state_d = StReq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_req_addr <= w_req_addr_d;
        end
    end

    fetch_buf #(
        .WIDTH (EW)
    ) u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({mem_rsp_data, r_req_addr}),
        .i_pop   (dec_valid && dec_ready),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign dec_valid = (w_count != 2'd0);
    assign dec_instr = w_head[EW-1:AW];
    assign dec_pc    = w_head[AW-1:0];
    assign opcode    = dec_instr[6:0];
    assign func3     = dec_instr[14:12];
    assign func7     = dec_instr[31:25];

endmodule
